grayscale_stream_ctrl: RTL
==========================

Name: grayscale_stream_ctrl

Overview:
Sequencer and flow controller for the registered, non-stallable RGB-to-grayscale datapath (module grayscale, 1-cycle latency, no enable).
- Accepts one frame of RGB pixels over a valid/ready handshake and feeds them through grayscale.
- Absorbs downstream backpressure in a 4-entry output FIFO.
- Tags each output pixel with start-of-line, end-of-line and end-of-frame flags for the downstream edge-detection stages.

Parameters:
- P_PIXEL_DEPTH, 24, RGB pixel width; must be a multiple of 3.
- P_SUBPIXEL_DEPTH, P_PIXEL_DEPTH/3, grayscale output width.
- P_DIM_WIDTH, 10, bit width of the frame width/height inputs and of the column/row counters.

Ports:
- I_CLK  in  1  clock.
- I_RESET_N  in  1  synchronous, active-low reset.
- I_START  in  1  start-of-frame request; sampled in IDLE only.
- I_FRAME_WIDTH  in  P_DIM_WIDTH  pixels per line; latched on start.
- I_FRAME_HEIGHT  in  P_DIM_WIDTH  lines per frame; latched on start.
- I_PIXEL_VALID  in  1  upstream RGB pixel valid.
- O_PIXEL_READY  out  1  controller can accept an RGB pixel.
- I_PIXEL  in  P_PIXEL_DEPTH  RGB pixel, red in the MSBs.
- O_GRAY_VALID  out  1  grayscale output valid.
- I_GRAY_READY  in  1  downstream ready.
- O_GRAY_PIXEL  out  P_SUBPIXEL_DEPTH  grayscale value.
- O_GRAY_SOL / O_GRAY_EOL / O_GRAY_EOF  out  1 each  tags for the current output pixel.
- O_BUSY  out  1  frame in progress.
- O_FRAME_DONE  out  1  one-cycle pulse when a frame has fully drained.

Behaviour:
- Clock and reset: single clock I_CLK. Reset is synchronous and active-low on I_RESET_N.
- Reset state: all outputs 0, state IDLE, FIFO emptied, in-flight bit cleared, counters 0. Reset mid-frame discards all data with no FRAME_DONE. The grayscale instance is reset with ~I_RESET_N.
- Upstream handshake: transfer occurs when I_PIXEL_VALID & O_PIXEL_READY. O_PIXEL_READY = (state==STREAM) & (fifo_count + inflight < 4), built from registered terms only.
- Datapath sequencing:
  - An accepted pixel drives grayscale in cycle N; inflight is set for cycle N+1.
  - In N+1 the datapath output plus its delayed tags is written to the FIFO.
  - Earliest O_GRAY_VALID is N+2.
  - Sustained throughput is 1 pixel/cycle when I_GRAY_READY stays high.
- Grayscale arithmetic is in the datapath: red×(2^-2+2^-5+2^-6) + green×(2^-1+2^-4+2^-6+2^-7) + blue×(2^-4+2^-5+2^-6), computed with right shifts. The result never exceeds the subpixel maximum.
- Downstream handshake:
  - FIFO pops when O_GRAY_VALID & I_GRAY_READY.
  - O_GRAY_VALID = FIFO not empty; outputs come from the FIFO head.
  - Data and tags hold stable while valid & !ready.
- Tags, computed at accept time from col/row:
  - SOL = (col==0).
  - EOL = (col==W-1).
  - EOF = EOL & (row==H-1).
  - col wraps to 0 on EOL, then row increments.
- FSM states and transitions:
  - IDLE: on I_START with W!=0 and H!=0, latch W/H, clear col/row, go to STREAM. I_START with either dimension 0 is ignored.
  - STREAM: on acceptance of the EOF pixel, go to DRAIN. O_PIXEL_READY is 0 from the next cycle.
  - DRAIN: on pop of the EOF-tagged entry, go to IDLE. O_FRAME_DONE is registered high for the following cycle only.
- O_BUSY = (state != IDLE).
- I_START outside IDLE is ignored. I_START is honoured in the same cycle O_FRAME_DONE is high.
- Boundary cases:
  - A full FIFO (count 4) or count 3 with inflight set deasserts ready. An entry cannot be lost.
  - Simultaneous FIFO write and pop in one cycle leaves count unchanged.
  - W=1 makes every pixel SOL and EOL.
  - W=1 with H=1 makes a single pixel carry SOL, EOL and EOF.

Decomposition:
- Package grayscale_ctrl_pkg holds:
  - state encodings IDLE/STREAM/DRAIN;
  - FIFO depth localparam 4;
  - tag bit indices within a FIFO entry (SOL, EOL, EOF);
  - entry width = P_SUBPIXEL_DEPTH+3.
- One sub-module, pixel_tag_fifo: 4-entry synchronous FIFO with registered count, simultaneous read/write, and active-low synchronous reset.
- The controller instantiates the existing grayscale module plus pixel_tag_fifo.

Test Plan:
1. Reset, then W=2, H=1. Feed 0xFF0000, 0x00FF00 back-to-back with I_GRAY_READY=1. Expect:
   - output 0x49 with SOL=1, then 0x92 with EOL=1, EOF=1;
   - first O_GRAY_VALID 2 cycles after the first handshake;
   - O_FRAME_DONE pulse 1 cycle after the last pop.
2. W=4, H=2 with continuous valid and ready. Expect:
   - 8 outputs in 8 consecutive cycles;
   - SOL on outputs 0 and 4, EOL on outputs 3 and 7, EOF only on output 7;
   - O_PIXEL_READY never drops before the EOF accept.
3. W=8, H=1 with I_GRAY_READY=0. Expect:
   - exactly 4 pixels accepted, then O_PIXEL_READY=0;
   - O_GRAY_PIXEL stable;
   - after releasing ready, all 8 outputs arrive in order with no loss or duplication.
4. 0xFFFFFF then 0x0000FF. Expect 0xF4, then 0x19.
5. Assert I_START mid-frame, and I_START with W=0 in IDLE. Expect both ignored, O_BUSY unchanged.
6. Drop I_RESET_N during STREAM with the FIFO holding 3 entries. Expect next cycle: O_GRAY_VALID=0, O_BUSY=0, O_PIXEL_READY=0, and no O_FRAME_DONE.

Source files
------------

// File: rtl/grayscale_ctrl_pkg.sv
// Shared types and constants for the grayscale stream controller and its output FIFO.
package grayscale_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } state_t;

  localparam int unsigned FifoDepth = 4;

  // Tag bits occupy the low end of a FIFO entry, gray value above them.
  localparam int unsigned TagEof = 0;
  localparam int unsigned TagEol = 1;
  localparam int unsigned TagSol = 2;

  function automatic int unsigned entry_width(input int unsigned subpixel_depth);
    return subpixel_depth + 3;
  endfunction

endpackage

// File: rtl/grayscale.sv
// Registered RGB-to-grayscale datapath: one-cycle latency, no enable, active-high sync reset.
module grayscale #(
  parameter int unsigned P_PIXEL_DEPTH    = 24,
  parameter int unsigned P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [P_PIXEL_DEPTH-1:0]    i_pixel,
  output logic [P_SUBPIXEL_DEPTH-1:0] o_gray
);

  logic [P_SUBPIXEL_DEPTH-1:0] w_r, w_g, w_b, w_sum;

  assign w_r = i_pixel[P_PIXEL_DEPTH-1 -: P_SUBPIXEL_DEPTH];
  assign w_g = i_pixel[2*P_SUBPIXEL_DEPTH-1 -: P_SUBPIXEL_DEPTH];
  assign w_b = i_pixel[P_SUBPIXEL_DEPTH-1:0];

  // Weights sum to just under 1, so the truncated total cannot overflow.
  assign w_sum = (w_r >> 2) + (w_r >> 5) + (w_r >> 6)
               + (w_g >> 1) + (w_g >> 4) + (w_g >> 6) + (w_g >> 7)
               + (w_b >> 4) + (w_b >> 5) + (w_b >> 6);

  always_ff @(posedge i_clk) begin
    if (i_reset) o_gray <= '0;
    else         o_gray <= w_sum;
  end

endmodule

// File: rtl/pixel_tag_fifo.sv
// Small synchronous FIFO for gray value plus tags; supports push and pop in the same cycle.
module pixel_tag_fifo
  import grayscale_ctrl_pkg::*;
#(
  parameter int unsigned P_WIDTH = 11
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_wr_en,
  input  logic [P_WIDTH-1:0]                 i_wr_data,
  input  logic                               i_rd_en,
  output logic [P_WIDTH-1:0]                 o_rd_data,
  output logic                               o_empty,
  output logic [$clog2(FifoDepth+1)-1:0]     o_count
);

  localparam int unsigned LP_PTR_W = $clog2(FifoDepth);
  localparam int unsigned LP_CNT_W = $clog2(FifoDepth + 1);

  logic [P_WIDTH-1:0]  r_mem [FifoDepth];
  logic [LP_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LP_CNT_W-1:0] r_count;
  logic                w_push, w_pop;

  assign w_pop  = i_rd_en & (r_count != '0);
  assign w_push = i_wr_en & ((r_count != LP_CNT_W'(FifoDepth)) | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + LP_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_W'(1);
        2'b01:   r_count <= r_count - LP_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer around the non-stallable grayscale datapath: tags pixels with SOL/EOL/EOF
// and absorbs downstream backpressure in a small FIFO sized against in-flight work.
module grayscale_stream_ctrl
  import grayscale_ctrl_pkg::*;
#(
  parameter int unsigned P_PIXEL_DEPTH    = 24,
  parameter int unsigned P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  parameter int unsigned P_DIM_WIDTH      = 10
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET_N,
  input  logic                        I_START,
  input  logic [P_DIM_WIDTH-1:0]      I_FRAME_WIDTH,
  input  logic [P_DIM_WIDTH-1:0]      I_FRAME_HEIGHT,
  input  logic                        I_PIXEL_VALID,
  output logic                        O_PIXEL_READY,
  input  logic [P_PIXEL_DEPTH-1:0]    I_PIXEL,
  output logic                        O_GRAY_VALID,
  input  logic                        I_GRAY_READY,
  output logic [P_SUBPIXEL_DEPTH-1:0] O_GRAY_PIXEL,
  output logic                        O_GRAY_SOL,
  output logic                        O_GRAY_EOL,
  output logic                        O_GRAY_EOF,
  output logic                        O_BUSY,
  output logic                        O_FRAME_DONE
);

  localparam int unsigned LP_ENTRY_W = entry_width(P_SUBPIXEL_DEPTH);
  localparam int unsigned LP_CNT_W   = $clog2(FifoDepth + 1);

  state_t                  r_state;
  logic [P_DIM_WIDTH-1:0]  r_width, r_height, r_col, r_row;
  logic                    r_inflight, r_tag_sol, r_tag_eol, r_tag_eof, r_done;

  logic                        w_accept, w_pop, w_empty, w_sol, w_eol, w_eof;
  logic [P_SUBPIXEL_DEPTH-1:0] w_gray;
  logic [LP_ENTRY_W-1:0]       w_wr_data, w_rd_data;
  logic [LP_CNT_W-1:0]         w_count;
  logic [LP_CNT_W:0]           w_occupancy;

  grayscale #(
    .P_PIXEL_DEPTH    (P_PIXEL_DEPTH),
    .P_SUBPIXEL_DEPTH (P_SUBPIXEL_DEPTH)
  ) u_grayscale (
    .i_clk   (I_CLK),
    .i_reset (~I_RESET_N),
    .i_pixel (I_PIXEL),
    .o_gray  (w_gray)
  );

  always_comb begin
    w_wr_data         = {w_gray, 3'b000};
    w_wr_data[TagSol] = r_tag_sol;
    w_wr_data[TagEol] = r_tag_eol;
    w_wr_data[TagEof] = r_tag_eof;
  end

  pixel_tag_fifo #(
    .P_WIDTH (LP_ENTRY_W)
  ) u_fifo (
    .i_clk     (I_CLK),
    .i_reset_n (I_RESET_N),
    .i_wr_en   (r_inflight),
    .i_wr_data (w_wr_data),
    .i_rd_en   (I_GRAY_READY),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Reserve a slot for the pixel still inside the datapath, which cannot be stalled.
  assign w_occupancy   = {1'b0, w_count} + {{LP_CNT_W{1'b0}}, r_inflight};
  assign O_PIXEL_READY = (r_state == StStream) && (w_occupancy < (LP_CNT_W+1)'(FifoDepth));
  assign w_accept      = I_PIXEL_VALID & O_PIXEL_READY;

  assign w_sol = (r_col == '0);
  assign w_eol = (r_col == r_width - P_DIM_WIDTH'(1));
  assign w_eof = w_eol & (r_row == r_height - P_DIM_WIDTH'(1));

  assign O_GRAY_VALID = ~w_empty;
  assign w_pop        = O_GRAY_VALID & I_GRAY_READY;
  assign O_GRAY_PIXEL = w_rd_data[LP_ENTRY_W-1 -: P_SUBPIXEL_DEPTH];
  assign O_GRAY_SOL   = w_rd_data[TagSol];
  assign O_GRAY_EOL   = w_rd_data[TagEol];
  assign O_GRAY_EOF   = w_rd_data[TagEof];
  assign O_BUSY       = (r_state != StIdle);
  assign O_FRAME_DONE = r_done;

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      r_state    <= StIdle;
      r_width    <= '0;
      r_height   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_inflight <= 1'b0;
      r_tag_sol  <= 1'b0;
      r_tag_eol  <= 1'b0;
      r_tag_eof  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_accept;
      if (w_accept) begin
        r_tag_sol <= w_sol;
        r_tag_eol <= w_eol;
        r_tag_eof <= w_eof;
      end
      case (r_state)
        StIdle: begin
          if (I_START && (I_FRAME_WIDTH != '0) && (I_FRAME_HEIGHT != '0)) begin
            r_width  <= I_FRAME_WIDTH;
            r_height <= I_FRAME_HEIGHT;
            r_col    <= '0;
            r_row    <= '0;
            r_state  <= StStream;
          end
        end
        StStream: begin
          if (w_accept) begin
            if (w_eol) begin
              r_col <= '0;
              r_row <= r_row + P_DIM_WIDTH'(1);
            end else begin
              r_col <= r_col + P_DIM_WIDTH'(1);
            end
            if (w_eof) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_pop && w_rd_data[TagEof]) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
